// File: rtl/bp_update_scheduler.sv
// Branch history table port controller: table clear after reset, lookup/update arbitration,
// in-order in-flight prediction tracking. Define BP_STATS_EN to add lookup/mispredict counters.
module bp_update_scheduler #(
    parameter int IDX_W     = 4,
    parameter int Q_DEPTH   = 4,
    parameter int MAX_STALL = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lk_valid,
    input  logic [31:0]      lk_pc,
    output logic             lk_ready,
    output logic             lk_pred,
    input  logic             res_valid,
    input  logic             res_taken,
    output logic             res_ready,
    output logic             mispredict,
    input  logic             flush,
    output logic             bht_we,
    output logic [IDX_W-1:0] bht_idx,
    output logic [1:0]       bht_wdata,
    input  logic [1:0]       bht_rdata,
    output logic             init_done
`ifdef BP_STATS_EN
    ,
    output logic [15:0]      stat_lookups,
    output logic [15:0]      stat_mispred
`endif
);

    localparam int PTR_W = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int ST_W  = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   init_cnt;

    logic [IDX_W-1:0]   q_idx [Q_DEPTH];
    logic [1:0]         q_ctr [Q_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   q_count;

    logic               pend_full;
    logic [IDX_W-1:0]   pend_idx;
    logic [1:0]         pend_data;
    logic [ST_W-1:0]    stall_cnt;

    logic               run;
    logic               q_full;
    logic               q_empty;
    logic               force_wr;
    logic               grant_lk;
    logic               lk_contend;
    logic               drain_ok;
    logic               pop;
    logic               lk_fire;
    logic               pend_wr;
    logic [IDX_W-1:0]   lk_idx;
    logic [1:0]         head_ctr;
    logic [1:0]         head_next;
    logic               unused_pc;

    assign lk_idx    = lk_pc[IDX_W-1:0];
    assign unused_pc = ^lk_pc[31:IDX_W];
    assign head_ctr  = q_ctr[rd_ptr];

    // Saturating 2-bit counter step for the resolving branch
    always_comb begin
        head_next = head_ctr;
        if (res_taken) begin
            if (head_ctr != 2'b11)
                head_next = head_ctr + 2'd1;
        end else begin
            if (head_ctr != 2'b00)
                head_next = head_ctr - 2'd1;
        end
    end

    // Port arbitration. Whether the pending update drains is judged before the lookup's
    // own readiness is known, so a blocked lookup still counts as contending here.
    always_comb begin
        run        = (state == S_RUN);
        q_full     = (q_count == CNT_W'(Q_DEPTH));
        q_empty    = (q_count == '0);
        force_wr   = run && pend_full && (stall_cnt == ST_W'(MAX_STALL));
        grant_lk   = run && !flush && !force_wr;
        lk_contend = lk_valid && grant_lk;
        drain_ok   = pend_full && (force_wr || !lk_contend);
        res_ready  = run && !flush && !q_empty && (!pend_full || drain_ok);
        pop        = res_valid && res_ready;
        lk_ready   = grant_lk && (!q_full || pop);
        lk_fire    = lk_valid && lk_ready;
        pend_wr    = run && pend_full && !lk_fire;
    end

    // rst_n gates the write strobe so the array is never written while reset is held
    always_comb begin
        bht_we    = rst_n && (!run || pend_wr);
        bht_idx   = lk_idx;
        bht_wdata = pend_data;
        if (!run) begin
            bht_idx   = init_cnt;
            bht_wdata = 2'b10;
        end else if (pend_wr) begin
            bht_idx = pend_idx;
        end
    end

    assign lk_pred = bht_rdata[1];

    always_ff @(posedge clk) begin
        if (lk_fire) begin
            q_idx[wr_ptr] <= lk_idx;
            q_ctr[wr_ptr] <= bht_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_INIT;
            init_cnt   <= '0;
            init_done  <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            q_count    <= '0;
            pend_full  <= 1'b0;
            pend_idx   <= '0;
            pend_data  <= 2'b00;
            stall_cnt  <= '0;
            mispredict <= 1'b0;
        end else begin
            mispredict <= 1'b0;
            case (state)
                S_INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == {IDX_W{1'b1}}) begin
                        state     <= S_RUN;
                        init_done <= 1'b1;
                    end
                end
                S_RUN: begin
                    mispredict <= pop && (res_taken != head_ctr[1]);
                    if (flush) begin
                        wr_ptr  <= '0;
                        rd_ptr  <= '0;
                        q_count <= '0;
                    end else begin
                        if (lk_fire)
                            wr_ptr <= wr_ptr + 1'b1;
                        if (pop)
                            rd_ptr <= rd_ptr + 1'b1;
                        q_count <= q_count + CNT_W'(lk_fire) - CNT_W'(pop);
                    end

                    if (pop) begin
                        pend_full <= 1'b1;
                        pend_idx  <= q_idx[rd_ptr];
                        pend_data <= head_next;
                    end else if (pend_wr) begin
                        pend_full <= 1'b0;
                    end

                    if (pend_wr)
                        stall_cnt <= '0;
                    else if (pend_full)
                        stall_cnt <= stall_cnt + 1'b1;
                end
                default: state <= S_INIT;
            endcase
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_lookups <= '0;
            stat_mispred <= '0;
        end else begin
            if (lk_fire && (stat_lookups != 16'hFFFF))
                stat_lookups <= stat_lookups + 16'd1;
            if (mispredict && (stat_mispred != 16'hFFFF))
                stat_mispred <= stat_mispred + 16'd1;
        end
    end
`endif

endmodule
